// File: rtl/stage_mm_sized_if.sv
// Memory-side bus of the MM stage: request, byte enables, write data,
// read data and the wait handshake.
interface stage_mm_sized_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DATA_ADDR_W = 32
);
  logic [DATA_W-1:0]      mem_data_w;
  logic [DATA_W/8-1:0]    mem_be;
  logic [DATA_ADDR_W-1:0] mem_addr;
  logic                   mem_read;
  logic                   mem_write;
  logic                   mem_atomic;
  logic [DATA_W-1:0]      mem_data_r;
  logic                   mem_wait;

  modport master (
    output mem_data_w, mem_be, mem_addr, mem_read, mem_write, mem_atomic,
    input  mem_data_r, mem_wait
  );

  modport slave (
    input  mem_data_w, mem_be, mem_addr, mem_read, mem_write, mem_atomic,
    output mem_data_r, mem_wait
  );
endinterface

// File: rtl/stage_mm_sized.sv
// Memory-access pipeline stage between EX and WB: sized loads/stores with
// byte enables, extension, misalignment detection, wait handshake and timeout.
module stage_mm_sized #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DATA_ADDR_W = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic                   is_atomic,
  input  logic [1:0]             size,
  input  logic                   sign_ext,
  input  logic                   reg_wr,
  input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
  input  logic [DATA_W-1:0]      reg_data_rd,
  input  logic [DATA_ADDR_W-1:0] alu_mem_addr,
  stage_mm_sized_if.master       mem,
  output logic                   mm_busy,
  output logic [DATA_W-1:0]      ffw_MM_data_wr,
  output logic                   misalign,
  output logic                   bus_timeout,
  output logic                   out_reg_wr,
  output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
  output logic [DATA_W-1:0]      out_reg_data_rd,
  output logic                   out_flush
);
  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned OB       = $clog2(NB);
  localparam int unsigned SIGN_TOP = (DATA_W >= 64) ? 63 : 31;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t state, state_nxt;
  logic [15:0] cnt;

  logic [DATA_ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0]      lat_data, res_hold;
  logic [1:0]             lat_size;
  logic                   lat_sx, lat_load, lat_store, lat_atomic, lat_reg_wr;
  logic [REG_ADDR_W-1:0]  lat_rd;

  logic [DATA_ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0]      cur_data;
  logic [1:0]             cur_size;
  logic                   cur_sx, cur_load, cur_store, cur_atomic;

  logic [OB-1:0]     off;
  int unsigned       lanes, nbits;
  logic              illegal;
  logic [NB-1:0]     be_ones, be;
  logic [DATA_W-1:0] d_ones, dmask, pat, wdata, sh, ldata, result;
  logic              sb, accept, expire;

  // In IDLE the access is described by the live inputs, otherwise by the latched copy.
  always_comb begin
    cur_addr   = alu_mem_addr;
    cur_data   = reg_data_rd;
    cur_size   = size;
    cur_sx     = sign_ext;
    cur_load   = is_load;
    cur_store  = is_store;
    cur_atomic = is_atomic;
    if (state != ST_IDLE) begin
      cur_addr   = lat_addr;
      cur_data   = lat_data;
      cur_size   = lat_size;
      cur_sx     = lat_sx;
      cur_load   = lat_load;
      cur_store  = lat_store;
      cur_atomic = lat_atomic;
    end
  end

  // Lane arithmetic: legality, byte enables, store replication, load extraction.
  always_comb begin
    off   = cur_addr[OB-1:0];
    lanes = 32'd1 << cur_size;
    if (lanes > NB) lanes = NB;
    nbits = lanes * 8;
    illegal = (cur_size == 2'd3 && DATA_W < 64) || ((32'(off) % lanes) != 0) ||
              (cur_atomic && (32'(cur_size) != OB));
    be_ones = '1;
    be      = (~(be_ones << lanes)) << off;
    d_ones  = '1;
    dmask   = ~(d_ones << nbits);
    pat     = cur_data & dmask;
    wdata   = '0;
    for (int unsigned k = 0; k < NB; k++)
      if ((k % lanes) == 0) wdata = wdata | (pat << (k * 8));
    sh = mem.mem_data_r >> (32'(off) * 32'd8);
    case (cur_size)
      2'd0:    sb = sh[7];
      2'd1:    sb = sh[15];
      2'd2:    sb = sh[31];
      default: sb = sh[SIGN_TOP];
    endcase
    ldata  = (sh & dmask) | ((cur_sx & sb) ? ~dmask : '0);
    result = (cur_load | cur_atomic) ? ldata : cur_data;
  end

  // Next-state logic and memory request drive.
  always_comb begin
    accept  = ~rst & en & ~stall & ~flush & (is_load | is_store | is_atomic);
    expire  = mem.mem_wait && (cnt == TO_LAST);
    state_nxt       = state;
    mm_busy         = (state != ST_IDLE);
    ffw_MM_data_wr  = result;
    mem.mem_read    = 1'b0;
    mem.mem_write   = 1'b0;
    mem.mem_atomic  = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_be      = '0;
    mem.mem_data_w  = '0;
    case (state)
      ST_IDLE: begin
        if (accept && !illegal) begin
          mem.mem_read   = cur_load;
          mem.mem_write  = cur_store;
          mem.mem_atomic = cur_atomic;
          mem.mem_addr   = cur_addr;
          mem.mem_be     = be;
          mem.mem_data_w = wdata;
          if (mem.mem_wait) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem.mem_read   = cur_load;
        mem.mem_write  = cur_store;
        mem.mem_atomic = cur_atomic;
        mem.mem_addr   = cur_addr;
        mem.mem_be     = be;
        mem.mem_data_w = wdata;
        if (!mem.mem_wait) state_nxt = stall ? ST_HOLD : ST_IDLE;
        else if (expire)   state_nxt = ST_IDLE;
      end
      ST_HOLD: begin
        ffw_MM_data_wr = res_hold;
        if (!stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, wait counter and latched access descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_size   <= '0;
      lat_sx     <= 1'b0;
      lat_load   <= 1'b0;
      lat_store  <= 1'b0;
      lat_atomic <= 1'b0;
      lat_reg_wr <= 1'b0;
      lat_rd     <= '0;
      res_hold   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_WAIT) begin
        cnt        <= '0;
        lat_addr   <= alu_mem_addr;
        lat_data   <= reg_data_rd;
        lat_size   <= size;
        lat_sx     <= sign_ext;
        lat_load   <= is_load;
        lat_store  <= is_store;
        lat_atomic <= is_atomic;
        lat_reg_wr <= reg_wr;
        lat_rd     <= reg_addr_rd;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + 16'd1;
      end
      if (state == ST_WAIT && !mem.mem_wait) res_hold <= result;
    end
  end

  // WB output registers plus the misalign / timeout pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flush       <= 1'b1;
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_reg_data_rd <= '0;
      misalign        <= 1'b0;
      bus_timeout     <= 1'b0;
    end else begin
      misalign    <= 1'b0;
      bus_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && !stall) begin
            if (accept && (illegal || mem.mem_wait)) begin
              out_flush  <= 1'b1;
              out_reg_wr <= 1'b0;
              misalign   <= illegal;
            end else begin
              out_flush       <= flush;
              out_reg_wr      <= reg_wr | is_load | is_atomic;
              out_reg_addr_rd <= reg_addr_rd;
              out_reg_data_rd <= result;
            end
          end
        end
        ST_WAIT: begin
          if (!mem.mem_wait && !stall) begin
            out_flush       <= 1'b0;
            out_reg_wr      <= lat_reg_wr | lat_load | lat_atomic;
            out_reg_addr_rd <= lat_rd;
            out_reg_data_rd <= result;
          end else begin
            out_flush   <= 1'b1;
            out_reg_wr  <= 1'b0;
            bus_timeout <= expire;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_flush       <= 1'b0;
            out_reg_wr      <= lat_reg_wr | lat_load | lat_atomic;
            out_reg_addr_rd <= lat_rd;
            out_reg_data_rd <= res_hold;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mm_sized.sv
// Directed bench for stage_mm_sized (DATA_W=32, TIMEOUT_CYC=4).
module tb_stage_mm_sized;
  logic clk = 1'b0;
  logic rst, en, stall, flush, is_load, is_store, is_atomic, sign_ext, reg_wr;
  logic [1:0]  size;
  logic [4:0]  reg_addr_rd, out_reg_addr_rd;
  logic [31:0] reg_data_rd, alu_mem_addr, ffw_MM_data_wr, out_reg_data_rd;
  logic mm_busy, misalign, bus_timeout, out_reg_wr, out_flush;
  int n_cmp = 0;
  int n_bad = 0;

  stage_mm_sized_if #(.DATA_W(32), .DATA_ADDR_W(32)) mem_bus ();

  stage_mm_sized #(.DATA_W(32), .DATA_ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush),
    .is_load(is_load), .is_store(is_store), .is_atomic(is_atomic),
    .size(size), .sign_ext(sign_ext), .reg_wr(reg_wr),
    .reg_addr_rd(reg_addr_rd), .reg_data_rd(reg_data_rd), .alu_mem_addr(alu_mem_addr),
    .mem(mem_bus.master), .mm_busy(mm_busy), .ffw_MM_data_wr(ffw_MM_data_wr),
    .misalign(misalign), .bus_timeout(bus_timeout), .out_reg_wr(out_reg_wr),
    .out_reg_addr_rd(out_reg_addr_rd), .out_reg_data_rd(out_reg_data_rd), .out_flush(out_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic at, input logic [1:0] sz,
                       input logic sx, input logic rw, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] mdr, input logic mw);
    en = 1'b1; stall = 1'b0; flush = 1'b0;
    is_load = ld; is_store = st; is_atomic = at; size = sz; sign_ext = sx; reg_wr = rw;
    alu_mem_addr = addr; reg_data_rd = data;
    mem_bus.mem_data_r = mdr; mem_bus.mem_wait = mw;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; reg_addr_rd = 5'd0;
    idle();
    tick(); tick();
    rst = 1'b0;
    check("rst_flush",   64'(out_flush), 64'h1);
    check("rst_wr",      64'(out_reg_wr), 64'h0);
    check("rst_data",    64'(out_reg_data_rd), 64'h0);
    check("rst_misal",   64'(misalign), 64'h0);
    check("rst_tmo",     64'(bus_timeout), 64'h0);
    check("rst_busy",    64'(mm_busy), 64'h0);
    check("rst_read",    64'(mem_bus.mem_read), 64'h0);

    // byte store, lane 3
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h103, 32'hAB, 32'h0, 1'b0); reg_addr_rd = 5'd3;
    #3;
    check("sb_be",    64'(mem_bus.mem_be), 64'h8);
    check("sb_wdata", 64'(mem_bus.mem_data_w), 64'hABABABAB);
    check("sb_write", 64'(mem_bus.mem_write), 64'h1);
    check("sb_addr",  64'(mem_bus.mem_addr), 64'h103);
    check("sb_busy",  64'(mm_busy), 64'h0);
    tick();
    check("sb_flush", 64'(out_flush), 64'h0);
    check("sb_wr",    64'(out_reg_wr), 64'h0);
    idle();
    #3;
    check("sb_write_drop", 64'(mem_bus.mem_write), 64'h0);
    tick();

    // signed half load, lane 2
    drive(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h102, 32'h0, 32'h80011234, 1'b0); reg_addr_rd = 5'd7;
    #3;
    check("lh_read", 64'(mem_bus.mem_read), 64'h1);
    check("lh_be",   64'(mem_bus.mem_be), 64'hC);
    check("lh_ffw",  64'(ffw_MM_data_wr), 64'hFFFF8001);
    tick();
    check("lh_data",  64'(out_reg_data_rd), 64'hFFFF8001);
    check("lh_wr",    64'(out_reg_wr), 64'h1);
    check("lh_flush", 64'(out_flush), 64'h0);
    check("lh_rd",    64'(out_reg_addr_rd), 64'h7);

    // unsigned byte load lane 1, signed byte load lane 3
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h101, 32'h0, 32'h80011234, 1'b0);
    tick();
    check("lbu_data", 64'(out_reg_data_rd), 64'h12);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80011234, 1'b0);
    tick();
    check("lb_data", 64'(out_reg_data_rd), 64'hFFFFFF80);

    // misaligned word, illegal double, atomic of wrong size
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0);
    #3;
    check("mis_read", 64'(mem_bus.mem_read), 64'h0);
    tick();
    check("mis_pulse", 64'(misalign), 64'h1);
    check("mis_flush", 64'(out_flush), 64'h1);
    check("mis_wr",    64'(out_reg_wr), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
    tick();
    check("dbl_pulse", 64'(misalign), 64'h1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
    #3;
    check("amo_bad_req", 64'(mem_bus.mem_atomic), 64'h0);
    tick();
    check("amo_bad_pulse", 64'(misalign), 64'h1);
    idle();
    tick();
    check("mis_clear", 64'(misalign), 64'h0);

    // atomic word, halfword store
    drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, 1'b0);
    #3;
    check("amo_req", 64'(mem_bus.mem_atomic), 64'h1);
    check("amo_be",  64'(mem_bus.mem_be), 64'hF);
    tick();
    check("amo_data", 64'(out_reg_data_rd), 64'hCAFEF00D);
    check("amo_wr",   64'(out_reg_wr), 64'h1);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'h102, 32'h1234BEEF, 32'h0, 1'b0);
    #3;
    check("sh_be",    64'(mem_bus.mem_be), 64'hC);
    check("sh_wdata", 64'(mem_bus.mem_data_w), 64'hBEEFBEEF);
    tick();

    // ALU result pass-through and flushed bubble
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h55, 32'h0, 1'b0); reg_addr_rd = 5'd4;
    tick();
    check("alu_wr",   64'(out_reg_wr), 64'h1);
    check("alu_data", 64'(out_reg_data_rd), 64'h55);
    check("alu_rd",   64'(out_reg_addr_rd), 64'h4);
    flush = 1'b1;
    tick();
    check("alu_flush", 64'(out_flush), 64'h1);

    // load with mem_wait high for three cycles
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1); reg_addr_rd = 5'd9;
    #3;
    check("w_read0", 64'(mem_bus.mem_read), 64'h1);
    check("w_busy0", 64'(mm_busy), 64'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1); reg_addr_rd = 5'd0;
    for (int i = 0; i < 2; i++) begin
      check("w_bubble", 64'(out_flush), 64'h1);
      check("w_busy",   64'(mm_busy), 64'h1);
      #3;
      check("w_read", 64'(mem_bus.mem_read), 64'h1);
      check("w_addr", 64'(mem_bus.mem_addr), 64'h200);
      tick();
    end
    check("w_bubble3", 64'(out_flush), 64'h1);
    check("w_busy3",   64'(mm_busy), 64'h1);
    mem_bus.mem_data_r = 32'hDEADBEEF; mem_bus.mem_wait = 1'b0;
    #3;
    check("w_read3", 64'(mem_bus.mem_read), 64'h1);
    check("w_ffw",   64'(ffw_MM_data_wr), 64'hDEADBEEF);
    tick();
    check("w_data",  64'(out_reg_data_rd), 64'hDEADBEEF);
    check("w_wr",    64'(out_reg_wr), 64'h1);
    check("w_flush", 64'(out_flush), 64'h0);
    check("w_rd",    64'(out_reg_addr_rd), 64'h9);
    check("w_idle",  64'(mm_busy), 64'h0);

    // timeout after four WAIT cycles
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #3;
      check("to_read", 64'(mem_bus.mem_read), 64'h1);
      check("to_nopulse", 64'(bus_timeout), 64'h0);
      tick();
    end
    check("to_pulse", 64'(bus_timeout), 64'h1);
    check("to_drop",  64'(mem_bus.mem_read), 64'h0);
    check("to_busy",  64'(mm_busy), 64'h0);
    check("to_flush", 64'(out_flush), 64'h1);
    idle();
    tick();
    check("to_clear", 64'(bus_timeout), 64'h0);

    // completion under stall: two stalled cycles then WB
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1); reg_addr_rd = 5'd11;
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0); reg_addr_rd = 5'd0;
    stall = 1'b1;
    #3;
    check("hd_read", 64'(mem_bus.mem_read), 64'h1);
    tick();
    mem_bus.mem_data_r = 32'hFFFFFFFF;
    #3;
    check("hd_busy",  64'(mm_busy), 64'h1);
    check("hd_noreq", 64'(mem_bus.mem_read), 64'h0);
    check("hd_flush", 64'(out_flush), 64'h1);
    check("hd_ffw",   64'(ffw_MM_data_wr), 64'h12345678);
    tick();
    stall = 1'b0;
    check("hd_flush2", 64'(out_flush), 64'h1);
    tick();
    check("hd_data", 64'(out_reg_data_rd), 64'h12345678);
    check("hd_wr",   64'(out_reg_wr), 64'h1);
    check("hd_fl",   64'(out_flush), 64'h0);
    check("hd_rd",   64'(out_reg_addr_rd), 64'hB);
    check("hd_idle", 64'(mm_busy), 64'h0);

    // reset in the middle of a waited access
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_read",  64'(mem_bus.mem_read), 64'h0);
    check("rm_busy",  64'(mm_busy), 64'h0);
    check("rm_flush", 64'(out_flush), 64'h1);
    check("rm_wr",    64'(out_reg_wr), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stage_mm_sized.md
Name: stage_mm_sized

Overview:
Parametrised memory-access pipeline stage that sits between STAGE_EX and STAGE_WB. It supports byte, halfword, word and (when DATA_W allows) doubleword loads and stores, with byte enables, sign/zero extension and misalignment detection. It honours a memory wait handshake, holding the pipeline through multi-cycle accesses, and aborts accesses that exceed a timeout.

Parameters:
DATA_W, 32, data path width; must be a power of two, minimum 32.
DATA_ADDR_W, 32, memory address width.
REG_ADDR_W, 5, register index width.
TIMEOUT_CYC, 255, maximum number of mem_wait cycles before the access is aborted; range 1 to 65535.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  stage enable
stall  in  1  downstream stall; holds the output registers
flush  in  1  the incoming instruction is a bubble
is_load  in  1  load operation
is_store  in  1  store operation
is_atomic  in  1  atomic read-modify-write operation; full width only
size  in  2  access size: 0=byte, 1=half, 2=word, 3=double
sign_ext  in  1  1 = sign-extend sub-width load data, 0 = zero-extend
reg_wr  in  1  non-memory register write
reg_addr_rd  in  REG_ADDR_W  destination register
reg_data_rd  in  DATA_W  ALU result or store data
alu_mem_addr  in  DATA_ADDR_W  byte address
mem_data_r  in  DATA_W  memory read data
mem_wait  in  1  memory not ready; access is complete in any cycle where the request is high and mem_wait=0
mem_data_w  out  DATA_W  store data, replicated across lanes
mem_be  out  DATA_W/8  byte enables
mem_addr  out  DATA_ADDR_W  access address
mem_read  out  1  read request
mem_write  out  1  write request
mem_atomic  out  1  atomic request
mm_busy  out  1  upstream stall request
ffw_MM_data_wr  out  DATA_W  forwarding value
misalign  out  1  one-cycle pulse on an illegal or misaligned access
bus_timeout  out  1  one-cycle pulse on access abort
out_reg_wr  out  1  to WB
out_reg_addr_rd  out  REG_ADDR_W  to WB
out_reg_data_rd  out  DATA_W  to WB
out_flush  out  1  to WB; marks a bubble

Behaviour:
- Reset values: state IDLE; wait counter 0; out_flush=1; out_reg_wr=0; out_reg_addr_rd=0; out_reg_data_rd=0; misalign=0; bus_timeout=0; all mem_* requests=0; mm_busy=0.
- Offset: OB = log2(DATA_W/8) low address bits; off = alu_mem_addr[OB-1:0]. Little-endian byte lanes.
- Legality:
  - size=3 with DATA_W<64 is illegal.
  - Misaligned means off is not a multiple of 2^size.
  - Atomic requires size = OB.
  - An illegal or misaligned access issues no request, pulses misalign, and sends a bubble (out_flush=1, out_reg_wr=0).
- Byte enables: mem_be has 2^size consecutive bits set, starting at lane off.
- Store data: the low 2^size bytes of reg_data_rd are replicated across all lanes.
- Load data: 2^size bytes are extracted starting at lane off, then sign- or zero-extended to DATA_W.
- FSM states:
  - IDLE:
    - A valid, legal memory op with en=1, stall=0 and flush=0 drives the mem_* signals combinationally from the inputs.
    - If mem_wait=0, the access completes in that cycle. This gives zero added latency, identical to a single-cycle memory.
    - If mem_wait=1, the stage latches addr, be, data, size, sign_ext, rd and the op flags, sets mm_busy, and goes to WAIT.
  - WAIT:
    - The mem_* signals are driven from the latched values; mm_busy=1; the counter increments each cycle.
    - Output registers load a bubble each cycle (out_flush=1).
    - When mem_wait=0: load data is captured. If stall=0, the result is written to the output registers and the FSM goes to IDLE. Otherwise it goes to HOLD.
    - If the counter reaches TIMEOUT_CYC while mem_wait is still 1: requests drop, bus_timeout pulses, a bubble is issued, and the FSM goes to IDLE.
    - The flush input is ignored in WAIT, because the instruction has already been accepted.
  - HOLD:
    - No request is driven; mm_busy=1.
    - When stall deasserts, the held result is written to the output registers and the FSM goes to IDLE.
- Output register update (en=1 and stall=0, or on a completion):
  - out_reg_wr = reg_wr, or load, or atomic.
  - out_flush = flush for the instruction.
  - out_reg_data_rd = load data for load/atomic, otherwise reg_data_rd.
- ffw_MM_data_wr carries the same value combinationally while the instruction is in the stage.
- Counter: 16-bit; cleared when entering WAIT.
- Reset mid-access: the FSM returns to IDLE in the next cycle and all requests drop; no result is produced.

Test Plan:
- DATA_W=32, byte store, addr 0x103, data 0xAB, mem_wait=0 -> mem_be=4'b1000, mem_data_w=0xABABABAB, mem_write=1 for 1 cycle, mm_busy=0.
- Half load, sign_ext=1, addr 0x102, mem_data_r=0x8001_1234 -> out_reg_data_rd=0xFFFF8001, out_reg_wr=1, out_flush=0.
- Word load, addr 0x101 -> mem_read=0, misalign pulses, out_flush=1.
- Load with mem_wait=1 for 3 cycles -> mm_busy=1 for 3 cycles, requests stable, WB gets 3 bubbles then the data.
- TIMEOUT_CYC=4, mem_wait held at 1 -> bus_timeout pulses after 4 WAIT cycles, mem_read drops, FSM returns to IDLE.
- Completion arrives with stall=1 for 2 cycles -> HOLD keeps the data; WB receives it on the first cycle with stall=0.
